pe_vec_mac: RTL and testbench

Parametrised vector multiply-accumulate processing element, successor to the scalar 2-D PE. Each accepted beat multiplies LANES operand pairs and reduces them through an adder tree. It accumulates a programmable number of beats and presents one result word under a valid/ready handshake. It sits between the operand feeders and the result collector of the convolution/attention datapath.

---
 rtl/pe_vec_mac.sv | 150 +++++++++++++++
 tb/tb_pe_vec_mac.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_vec_mac.sv
// Vector multiply-accumulate PE: LANES products per beat reduced by an adder tree,
// accumulated over a programmable beat count, result returned under valid/ready.
module pe_vec_mac #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int LEN_W  = 8,
    parameter int SIGNED = 1,
    localparam int ACC_W = 2*DATA_W + $clog2(LANES) + LEN_W
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic                      i_start,
    input  logic [LEN_W-1:0]          i_len,
    input  logic                      i_valid,
    input  logic [LANES*DATA_W-1:0]   i_r1,
    input  logic [LANES*DATA_W-1:0]   i_r2,
    input  logic                      i_ready,
    output logic [ACC_W-1:0]          o_mat,
    output logic                      o_flag,
    output logic                      o_busy
);

    localparam int PROD_W = 2*DATA_W;
    localparam int MUL_W  = 2*DATA_W + 2;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int NODES  = 2*LANES - 1;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               sum_vld_q, sum_vld_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   mat_q, mat_d;
    logic               flag_q, flag_d;

    logic [SUM_W-1:0]   node [NODES];
    logic [ACC_W-1:0]   sum_ext;
    logic [ACC_W-1:0]   acc_final;
    logic [LEN_W-1:0]   cnt_inc;

    // Heap-ordered adder tree: leaves at LANES-1.., node i = child 2i+1 + child 2i+2.
    always_comb begin : tree_p
        logic [MUL_W-1:0]  a_ext;
        logic [MUL_W-1:0]  b_ext;
        logic [MUL_W-1:0]  prod_full;
        logic [PROD_W-1:0] prod;
        for (int n = 0; n < NODES; n++) node[n] = '0;
        for (int k = 0; k < LANES; k++) begin
            if (SIGNED != 0) begin
                a_ext = MUL_W'($signed(i_r1[k*DATA_W +: DATA_W]));
                b_ext = MUL_W'($signed(i_r2[k*DATA_W +: DATA_W]));
            end else begin
                a_ext = MUL_W'(i_r1[k*DATA_W +: DATA_W]);
                b_ext = MUL_W'(i_r2[k*DATA_W +: DATA_W]);
            end
            prod_full = a_ext * b_ext;
            prod      = prod_full[PROD_W-1:0];
            if (SIGNED != 0) node[LANES-1+k] = SUM_W'($signed(prod));
            else             node[LANES-1+k] = SUM_W'(prod);
        end
        for (int i = LANES-2; i >= 0; i--) node[i] = node[2*i+1] + node[2*i+2];
    end

    always_comb begin
        if (SIGNED != 0) sum_ext = ACC_W'($signed(sum_q));
        else             sum_ext = ACC_W'(sum_q);
    end

    assign cnt_inc   = cnt_q + LEN_W'(1);
    assign acc_final = acc_q + (sum_vld_q ? sum_ext : '0);

    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        sum_vld_d = sum_vld_q;
        acc_d     = acc_q;
        mat_d     = mat_q;
        flag_d    = flag_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    len_d     = (i_len == '0) ? LEN_W'(1) : i_len;
                    cnt_d     = '0;
                    sum_d     = '0;
                    sum_vld_d = 1'b0;
                    acc_d     = '0;
                    state_d   = S_ACC;
                end
            end
            S_ACC: begin
                if (i_valid) begin
                    sum_d     = node[0];
                    sum_vld_d = 1'b1;
                    acc_d     = acc_final;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                acc_d     = acc_final;
                sum_vld_d = 1'b0;
                mat_d     = acc_final;
                flag_d    = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (i_ready) begin
                    flag_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            acc_q     <= '0;
            mat_q     <= '0;
            flag_q    <= 1'b0;
        end else if (en) begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
            acc_q     <= acc_d;
            mat_q     <= mat_d;
            flag_q    <= flag_d;
        end
    end

    assign o_mat  = mat_q;
    assign o_flag = flag_q;
    assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_pe_vec_mac.sv
// Bench for pe_vec_mac: directed transactions push expected results into a queue;
// a monitor pops and compares each time o_flag rises.
module tb_pe_vec_mac;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int LEN_W  = 8;
    localparam int ACC_W  = 2*DATA_W + 2 + LEN_W;
    localparam int W      = LANES*DATA_W;

    logic             clk = 1'b0;
    logic             rstn;
    logic             en;
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic             i_valid;
    logic [W-1:0]     i_r1;
    logic [W-1:0]     i_r2;
    logic             i_ready;
    logic [ACC_W-1:0] o_mat;
    logic             o_flag;
    logic             o_busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [ACC_W-1:0] exp_q [$];
    logic             prev_flag = 1'b0;

    pe_vec_mac #(.DATA_W(DATA_W), .LANES(LANES), .LEN_W(LEN_W), .SIGNED(1)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .i_start (i_start),
        .i_len   (i_len),
        .i_valid (i_valid),
        .i_r1    (i_r1),
        .i_r2    (i_r2),
        .i_ready (i_ready),
        .o_mat   (o_mat),
        .o_flag  (o_flag),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: one comparison per result presentation.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_flag = 1'b0;
        end else begin
            if (o_flag && !prev_flag) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %0h expected none", o_mat);
                end else begin
                    check("result", 64'(o_mat), 64'(exp_q.pop_front()));
                end
            end
            prev_flag = o_flag;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // One complete transaction; caller stands just after a falling edge.
    task automatic run_txn(input logic [LEN_W-1:0] len, input int nb,
                           input logic [W-1:0] a [4], input logic [W-1:0] b [4],
                           input int gap [4], input int stall_before, input int ready_wait,
                           input bit noise, input logic [ACC_W-1:0] exp_v, input string nm);
        exp_q.push_back(exp_v);
        i_ready = (ready_wait == 0);
        i_start = 1'b1;
        i_len   = len;
        cyc();
        i_start = 1'b0;
        for (int k = 0; k < nb; k++) begin
            for (int g = 0; g < gap[k]; g++) begin
                if (noise) begin
                    i_start = 1'b1;
                    i_len   = 8'd1;
                end
                cyc();
                i_start = 1'b0;
            end
            i_valid = 1'b1;
            i_r1    = a[k];
            i_r2    = b[k];
            if (k == stall_before) begin
                en = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    cyc();
                    #2 check({nm, "_stall_busy"}, 64'(o_busy), 64'd1);
                end
                en = 1'b1;
            end
            cyc();
            i_valid = 1'b0;
        end
        #2 check({nm, "_flag_early"}, 64'(o_flag), 64'd0);
        cyc();
        #2 check({nm, "_flag_lat2"}, 64'(o_flag), 64'd1);
        check({nm, "_busy_done"}, 64'(o_busy), 64'd1);
        for (int r = 0; r < ready_wait; r++) begin
            if (noise) i_start = 1'b1;
            cyc();
            #2 check({nm, "_hold_flag"}, 64'(o_flag), 64'd1);
            check({nm, "_hold_mat"}, 64'(o_mat), 64'(exp_v));
        end
        i_ready = 1'b1;
        if (noise) i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        #2 check({nm, "_flag_clr"}, 64'(o_flag), 64'd0);
        check({nm, "_busy_clr"}, 64'(o_busy), 64'd0);
        check({nm, "_mat_kept"}, 64'(o_mat), 64'(exp_v));
        if (noise) begin
            cyc();
            #2 check({nm, "_idle_after"}, 64'(o_busy), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v1, v2, vn, va, vb, v80, v7f;
        logic [W-1:0] a [4];
        logic [W-1:0] b [4];
        int           gp [4];
        logic signed [ACC_W-1:0] e_sgn;

        v1  = 32'h04030201;   // lanes 1,2,3,4
        v2  = 32'h06050403;   // lanes 3,4,5,6
        vn  = 32'hFCFDFEFF;   // lanes -1,-2,-3,-4
        va  = 32'h281E140A;   // lanes 10,20,30,40
        vb  = 32'h01010101;
        v80 = 32'h80808080;
        v7f = 32'h7F7F7F7F;

        rstn = 1'b0; en = 1'b1; i_start = 1'b0; i_len = '0; i_valid = 1'b0;
        i_r1 = '0; i_r2 = '0; i_ready = 1'b1;
        #2;
        check("rst_mat", 64'(o_mat), 64'd0);
        check("rst_flag", 64'(o_flag), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        cyc();
        rstn = 1'b1;
        cyc();

        // Single beat: 3+8+15+24 = 50
        a = '{v1, v1, v1, v1}; b = '{v2, v2, v2, v2}; gp = '{0, 0, 0, 0};
        run_txn(8'd1, 1, a, b, gp, -1, 0, 1'b0, 26'd50, "single");

        // Three beats with gaps 0,2,1
        gp = '{0, 2, 1, 0};
        run_txn(8'd3, 3, a, b, gp, -1, 0, 1'b0, 26'd150, "gaps");

        // Signed corner: 2 beats of 4 x (-128*127) = -130048
        a = '{v80, v80, v80, v80}; b = '{v7f, v7f, v7f, v7f}; gp = '{0, 0, 0, 0};
        e_sgn = -130048;
        run_txn(8'd2, 2, a, b, gp, -1, 0, 1'b0, e_sgn, "signed");

        // Mixed len=4: 50 - 50 + 100 + 64516 = 64616, first without then with stall/backpressure/start noise
        a = '{v1, vn, va, v7f}; b = '{v2, v2, vb, v7f}; gp = '{0, 1, 0, 0};
        run_txn(8'd4, 4, a, b, gp, -1, 0, 1'b0, 26'd64616, "mix");
        run_txn(8'd4, 4, a, b, gp, 2, 4, 1'b1, 26'd64616, "mix_stall");

        // len=0 behaves as len=1
        a = '{v1, v1, v1, v1}; b = '{v2, v2, v2, v2}; gp = '{0, 0, 0, 0};
        run_txn(8'd0, 1, a, b, gp, -1, 0, 1'b0, 26'd50, "len0");

        // Reset during ACC discards the partial run
        exp_q.push_back(26'd150);
        i_start = 1'b1; i_len = 8'd3;
        cyc();
        i_start = 1'b0;
        i_valid = 1'b1; i_r1 = v1; i_r2 = v2;
        cyc();
        i_valid = 1'b0;
        #2 check("pre_rst_busy", 64'(o_busy), 64'd1);
        rstn = 1'b0;
        #1;
        check("async_rst_mat", 64'(o_mat), 64'd0);
        check("async_rst_flag", 64'(o_flag), 64'd0);
        check("async_rst_busy", 64'(o_busy), 64'd0);
        void'(exp_q.pop_back());
        cyc();
        rstn = 1'b1;
        cyc();
        a = '{vn, vn, vn, vn};
        run_txn(8'd1, 1, a, b, gp, -1, 0, 1'b0, -26'sd50, "after_rst");

        repeat (3) cyc();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
